dmem_arbiter: RTL and testbench
===============================

// Module: dmem_arbiter
// PURPOSE
//   Round-robin arbiter sharing one synchronous data memory between core_count processor cores.
//   Each core presents a request with its AR/DR/write-enable values and waits for a one-cycle grant.
//   The arbiter serialises accesses, drives the single memory port, and returns read data with the grant.
//   Sits between the per-core AR_to_mem/DR_out/mem_write outputs and the shared data memory.
// PARAMETERS
//   core_count  4   number of requesting cores (2..16)
//   reg_width   12  address and data width; equals core register width
//   idx_width   $clog2(core_count)  width of the granted-core index (derived, not overridden)
// PORTS
//   clk        in   1                  single clock, rising edge
//   reset      in   1                  synchronous, active-low reset
//   req        in   core_count         per-core access request; held high until the core samples its gnt
//   we         in   core_count         per-core write flag, qualified by req
//   addr       in   core_count*reg_width  packed per-core addresses (core i at [i*reg_width +: reg_width])
//   wdata      in   core_count*reg_width  packed per-core write data (from DR_out)
//   gnt        out  core_count         one-hot, one-cycle completion pulse
//   rdata      out  reg_width          read data; valid while gnt is high for a read
//   mem_en     out  1                  memory access strobe
//   mem_we     out  1                  memory write strobe
//   mem_addr   out  reg_width          memory address
//   mem_wdata  out  reg_width          memory write data
//   mem_rdata  in   reg_width          memory read data, valid one cycle after mem_en
//   busy       out  1                  high in every state except IDLE
// BEHAVIOUR
//   Reset (reset==0 at clk edge): state=IDLE; gnt, mem_en, mem_we=0; mem_addr, mem_wdata, rdata=0; last=core_count-1.
//   Reset mid-access aborts the transfer: no gnt is issued, and a write already strobed is not rolled back.
//   FSM: IDLE -> ACCESS -> CAPTURE -> DONE -> IDLE.
//   - IDLE: if |req, pick winner = first asserted req scanning from (last+1) mod core_count upward with wrap.
//     Register idx, then mem_addr/mem_wdata from that core's slices, mem_we=we[idx], mem_en=1; go to ACCESS. If no req, stay in IDLE.
//   - ACCESS: mem_en/mem_we are high for exactly this cycle; the memory samples the request at the end of the cycle.
//   - CAPTURE: mem_en=mem_we=0; rdata<=mem_rdata if the access was a read, else rdata holds.
//   - DONE: gnt[idx]=1 for this cycle only; last<=idx; go to IDLE.
//   Latency: req high in IDLE at cycle 0 -> gnt in cycle 3. One access per 4 cycles.
//   Request inputs are sampled only in IDLE; changes to req/we/addr/wdata after the pick are ignored.
//   A core must drop req on the edge at which it samples gnt=1. If req is still high in IDLE, it is a new request.
//   Simultaneous requests are resolved purely by the round-robin order. There is no starvation: the wait is bounded by core_count accesses.
//   A req that drops before its grant is a protocol violation; the access still completes.
// CONFIGURATION
//   `DMEM_ARB_STATS_EN defined: adds output grant_cnt [core_count*8], one 8-bit counter per core.
//     The counter increments on each gnt[i], saturates at 255, and clears on reset.
//   Undefined: no grant_cnt port and no counter logic; all other behaviour is identical.
// STRUCTURE
//   Package dmem_arb_pkg holds the state enum (IDLE=2'd0, ACCESS=2'd1, CAPTURE=2'd2, DONE=2'd3) and the STAT_WIDTH=8 constant.
//   Sub-module rr_pick: combinational round-robin picker.
//     Inputs: req, last. Outputs: winner index and a valid flag.
//     Implemented as a rotate, priority-encode, un-rotate sequence.
//   Top level: FSM, captured request registers, memory-port drive, rdata/gnt registers, and the optional stats.
// TESTING
//   1. core 2 reads addr 12'h005 (mem holds 12'hABC) -> mem_en in cycle 1 with mem_addr=12'h005; gnt=4'b0100 and rdata=12'hABC in cycle 3.
//   2. core 0 writes 12'h123 to 12'h010 -> mem_we=1 for one cycle only; a later core-1 read of 12'h010 returns 12'h123.
//   3. All four req high from IDLE after reset -> grants in order core 0,1,2,3, each 4 cycles apart; cores then repeat in order 0,1,2,3.
//   4. core 3 holds req high continuously while core 1 requests once -> grants alternate 3,1,3 with no starvation.
//   5. reset asserted during CAPTURE -> next cycle state IDLE with all outputs 0; no gnt pulse appears.
//   6. With DMEM_ARB_STATS_EN, 300 grants to core 0 -> grant_cnt[7:0]=255 (saturates), and the other cores' counters are unchanged.

Source files
------------

// File: rtl/dmem_arb_pkg.sv
// ============================================================================
// Module : dmem_arb_pkg
// Brief  : Shared state encoding and constants for the data-memory arbiter.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package dmem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ACCESS  = 2'd1,
        CAPTURE = 2'd2,
        DONE    = 2'd3
    } state_t;

    localparam int STAT_WIDTH = 8;

endpackage

`default_nettype wire

// File: rtl/dmem_arbiter_rr_pick.sv
// ============================================================================
// Module : rr_pick
// Brief  : Combinational round-robin picker (rotate, priority-encode, un-rotate).
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module rr_pick #(
    parameter int core_count = 4,
    parameter int idx_width  = $clog2(core_count)
) (
    input  logic [core_count-1:0] i_req,
    input  logic [idx_width-1:0]  i_last,
    output logic [idx_width-1:0]  o_winner,
    output logic                  o_valid
);

    int                    w_start;
    int                    w_enc;
    int                    w_sum;
    logic [core_count-1:0] w_rot;

    always_comb begin
        w_start = int'(i_last) + 1;
        if (w_start >= core_count) w_start = 0;

        // Rotate so the core just after the last winner sits at bit 0.
        w_rot = '0;
        for (int j = 0; j < core_count; j++) begin
            w_rot[j] = i_req[((j + w_start) >= core_count) ? (j + w_start - core_count)
                                                           : (j + w_start)];
        end

        w_enc = 0;
        for (int j = core_count - 1; j >= 0; j--) begin
            if (w_rot[j]) w_enc = j;
        end

        w_sum = w_enc + w_start;
        if (w_sum >= core_count) w_sum = w_sum - core_count;
    end

    assign o_winner = idx_width'(w_sum);
    assign o_valid  = |i_req;

endmodule

`default_nettype wire

// File: rtl/dmem_arbiter.sv
// ============================================================================
// Module : dmem_arbiter
// Brief  : Round-robin arbiter sharing one synchronous data memory among cores.
//          Optional per-core grant counters when DMEM_ARB_STATS_EN is defined.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int core_count = 4,
    parameter int reg_width  = 12,
    parameter int idx_width  = $clog2(core_count)
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic [core_count-1:0]           req,
    input  logic [core_count-1:0]           we,
    input  logic [core_count*reg_width-1:0] addr,
    input  logic [core_count*reg_width-1:0] wdata,
    output logic [core_count-1:0]           gnt,
    output logic [reg_width-1:0]            rdata,
    output logic                            mem_en,
    output logic                            mem_we,
    output logic [reg_width-1:0]            mem_addr,
    output logic [reg_width-1:0]            mem_wdata,
    input  logic [reg_width-1:0]            mem_rdata,
    output logic                            busy
`ifdef DMEM_ARB_STATS_EN
    ,
    output logic [core_count*STAT_WIDTH-1:0] grant_cnt
`endif
);

    state_t                  r_state;
    logic [idx_width-1:0]    r_idx;
    logic [idx_width-1:0]    r_last;
    logic                    r_wr;
    logic [core_count-1:0]   r_gnt;
    logic [reg_width-1:0]    r_rdata;
    logic                    r_mem_en;
    logic                    r_mem_we;
    logic [reg_width-1:0]    r_mem_addr;
    logic [reg_width-1:0]    r_mem_wdata;

    logic [idx_width-1:0]    w_winner;
    logic                    w_valid;

    rr_pick #(
        .core_count (core_count),
        .idx_width  (idx_width)
    ) u_rr_pick (
        .i_req    (req),
        .i_last   (r_last),
        .o_winner (w_winner),
        .o_valid  (w_valid)
    );

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state     <= IDLE;
            r_idx       <= '0;
            r_last      <= idx_width'(core_count - 1);
            r_wr        <= 1'b0;
            r_gnt       <= '0;
            r_rdata     <= '0;
            r_mem_en    <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
        end else begin
            r_gnt <= '0;
            case (r_state)
                IDLE: begin
                    if (w_valid) begin
                        r_idx       <= w_winner;
                        r_wr        <= we[w_winner];
                        r_mem_en    <= 1'b1;
                        r_mem_we    <= we[w_winner];
                        r_mem_addr  <= addr[int'(w_winner)*reg_width +: reg_width];
                        r_mem_wdata <= wdata[int'(w_winner)*reg_width +: reg_width];
                        r_state     <= ACCESS;
                    end
                end
                ACCESS: begin
                    r_mem_en <= 1'b0;
                    r_mem_we <= 1'b0;
                    r_state  <= CAPTURE;
                end
                CAPTURE: begin
                    // Memory output is valid now, one cycle after the strobe.
                    if (!r_wr) r_rdata <= mem_rdata;
                    r_gnt[r_idx] <= 1'b1;
                    r_state      <= DONE;
                end
                DONE: begin
                    r_last  <= r_idx;
                    r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign gnt       = r_gnt;
    assign rdata     = r_rdata;
    assign mem_en    = r_mem_en;
    assign mem_we    = r_mem_we;
    assign mem_addr  = r_mem_addr;
    assign mem_wdata = r_mem_wdata;
    assign busy      = (r_state != IDLE);

`ifdef DMEM_ARB_STATS_EN
    for (genvar i = 0; i < core_count; i++) begin : g_stats
        logic [STAT_WIDTH-1:0] r_cnt;

        always_ff @(posedge clk) begin
            if (!reset) begin
                r_cnt <= '0;
            end else if (r_gnt[i] && (r_cnt != {STAT_WIDTH{1'b1}})) begin
                r_cnt <= r_cnt + 1'b1;
            end
        end

        assign grant_cnt[i*STAT_WIDTH +: STAT_WIDTH] = r_cnt;
    end
`endif

endmodule

`default_nettype wire

// File: tb/tb_dmem_arbiter.sv
// ============================================================================
// Module : tb_dmem_arbiter
// Brief  : Self-checking bench for dmem_arbiter with a behavioural reference.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_dmem_arbiter;

    localparam int N = 4;
    localparam int W = 12;

    logic           clk = 1'b0;
    logic           reset;
    logic [N-1:0]   req;
    logic [N-1:0]   we;
    logic [N*W-1:0] addr;
    logic [N*W-1:0] wdata;
    logic [N-1:0]   gnt;
    logic [W-1:0]   rdata;
    logic           mem_en;
    logic           mem_we;
    logic [W-1:0]   mem_addr;
    logic [W-1:0]   mem_wdata;
    logic [W-1:0]   mem_rdata;
    logic           busy;
`ifdef DMEM_ARB_STATS_EN
    logic [N*8-1:0] grant_cnt;
`endif

    always #5 clk = ~clk;

    dmem_arbiter #(
        .core_count (N),
        .reg_width  (W)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .req       (req),
        .we        (we),
        .addr      (addr),
        .wdata     (wdata),
        .gnt       (gnt),
        .rdata     (rdata),
        .mem_en    (mem_en),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .busy      (busy)
`ifdef DMEM_ARB_STATS_EN
        ,
        .grant_cnt (grant_cnt)
`endif
    );

    int errors = 0;
    int checks = 0;
    int m_last;
    int we_strobes = 0;

    // Memory background pattern; location 0x005 holds 0xABC until written.
    function automatic logic [W-1:0] bg(input logic [W-1:0] a);
        return (a == 12'h005) ? 12'hABC : (a ^ 12'h5A5);
    endfunction

    logic [W-1:0] mem       [0:4095];
    bit           mem_valid [0:4095];
    logic [W-1:0] exp_mem   [0:4095];
    bit           exp_valid [0:4095];

    always @(posedge clk) begin
        if (mem_en) begin
            mem_rdata <= mem_valid[mem_addr] ? mem[mem_addr] : bg(mem_addr);
            if (mem_we) begin
                mem[mem_addr]       <= mem_wdata;
                mem_valid[mem_addr] <= 1'b1;
                we_strobes          <= we_strobes + 1;
            end
        end
    end

    function automatic logic [W-1:0] model_read(input logic [W-1:0] a);
        return exp_valid[a] ? exp_mem[a] : bg(a);
    endfunction

    function automatic int rr_expect(input logic [N-1:0] r, input int last);
        for (int k = 1; k <= N; k++) begin
            if (r[(last + k) % N]) return (last + k) % N;
        end
        return -1;
    endfunction

    function automatic logic [N-1:0] onehot(input int c);
        logic [N-1:0] v;
        v = '0;
        if (c >= 0) v[c] = 1'b1;
        return v;
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic set_core(input int c, input logic w, input logic [W-1:0] a, input logic [W-1:0] d);
        we[c]          = w;
        addr[c*W +: W] = a;
        wdata[c*W +: W] = d;
    endtask

    task automatic wait_gnt(output logic [N-1:0] g, output int lat);
        bit done;
        done = 0;
        g    = '0;
        lat  = 0;
        while (!done && lat < 16) begin
            tick();
            lat++;
            if (gnt !== '0) begin
                g    = gnt;
                done = 1;
            end
        end
        if (!done) lat = -1;
    endtask

    task automatic do_reset;
        req   = '0;
        we    = '0;
        addr  = '0;
        wdata = '0;
        reset = 1'b0;
        tick();
        tick();
        reset  = 1'b1;
        m_last = N - 1;
    endtask

    task automatic test_reset;
        do_reset();
        reset = 1'b0;
        tick();
        checks++;
        if (gnt !== '0) begin
            errors++; $display("FAIL reset_gnt: got %b want 0", gnt);
        end
        checks++;
        if ({mem_en, mem_we, busy} !== 3'b000) begin
            errors++; $display("FAIL reset_ctrl: got en/we/busy=%b want 000", {mem_en, mem_we, busy});
        end
        checks++;
        if ({mem_addr, mem_wdata, rdata} !== '0) begin
            errors++; $display("FAIL reset_data: got addr=%h wdata=%h rdata=%h want 0", mem_addr, mem_wdata, rdata);
        end
        reset = 1'b1;
        tick();
    endtask

    task automatic test_read;
        logic [W-1:0] exp;
        exp = model_read(12'h005);
        set_core(2, 1'b0, 12'h005, 12'h000);
        req[2] = 1'b1;
        tick();
        checks++;
        if ({mem_en, mem_we, mem_addr, busy} !== {1'b1, 1'b0, 12'h005, 1'b1}) begin
            errors++; $display("FAIL read_strobe: got en=%b we=%b addr=%h busy=%b want 1 0 005 1", mem_en, mem_we, mem_addr, busy);
        end
        tick();
        checks++;
        if ({gnt, mem_en} !== 5'b0) begin
            errors++; $display("FAIL read_capture: got gnt=%b en=%b want 0", gnt, mem_en);
        end
        tick();
        checks++;
        if (gnt !== 4'b0100) begin
            errors++; $display("FAIL read_gnt: got %b want 0100", gnt);
        end
        checks++;
        if (rdata !== exp) begin
            errors++; $display("FAIL read_data: got %h want %h", rdata, exp);
        end
        req[2] = 1'b0;
        m_last = 2;
        tick();
        checks++;
        if ({gnt, busy} !== 5'b0) begin
            errors++; $display("FAIL read_idle: got gnt=%b busy=%b want 0", gnt, busy);
        end
    endtask

    task automatic test_write_read;
        logic [N-1:0] g;
        int           lat;
        int           s0;
        s0 = we_strobes;
        set_core(0, 1'b1, 12'h010, 12'h123);
        req[0] = 1'b1;
        wait_gnt(g, lat);
        req[0] = 1'b0;
        we[0]  = 1'b0;
        exp_mem[12'h010]   = 12'h123;
        exp_valid[12'h010] = 1'b1;
        m_last = 0;
        checks++;
        if (g !== 4'b0001 || lat != 3) begin
            errors++; $display("FAIL write_gnt: got %b lat %0d want 0001 lat 3", g, lat);
        end
        checks++;
        if (we_strobes - s0 != 1) begin
            errors++; $display("FAIL write_strobe_count: got %0d want 1", we_strobes - s0);
        end
        set_core(1, 1'b0, 12'h010, 12'h000);
        req[1] = 1'b1;
        wait_gnt(g, lat);
        req[1] = 1'b0;
        m_last = 1;
        checks++;
        if (g !== 4'b0010 || rdata !== model_read(12'h010)) begin
            errors++; $display("FAIL readback: got gnt=%b rdata=%h want 0010 %h", g, rdata, model_read(12'h010));
        end
        tick();
    endtask

    task automatic test_all_req;
        logic [N-1:0] g;
        int           lat;
        int           e;
        do_reset();
        for (int c = 0; c < N; c++) set_core(c, 1'b0, W'($urandom_range(0, 31)), '0);
        req = '1;
        for (int k = 0; k < 2 * N; k++) begin
            wait_gnt(g, lat);
            e = rr_expect(req, m_last);
            checks++;
            if (g !== onehot(e) || e != (k % N)) begin
                errors++; $display("FAIL all_req_order[%0d]: got %b want %b", k, g, onehot(k % N));
            end
            checks++;
            if (lat != ((k == 0) ? 3 : 4)) begin
                errors++; $display("FAIL all_req_spacing[%0d]: got %0d want %0d", k, lat, (k == 0) ? 3 : 4);
            end
            checks++;
            if (rdata !== model_read(addr[e*W +: W])) begin
                errors++; $display("FAIL all_req_data[%0d]: got %h want %h", k, rdata, model_read(addr[e*W +: W]));
            end
            m_last = e;
            if (e >= 0) addr[e*W +: W] = W'($urandom_range(0, 31));
        end
        req = '0;
        tick();
        tick();
    endtask

    task automatic test_hold_req;
        logic [N-1:0] g;
        logic [N-1:0] vec;
        int           lat;
        int           e;
        set_core(3, 1'b0, 12'h020, '0);
        set_core(1, 1'b0, 12'h021, '0);
        req[3] = 1'b1;
        vec    = req;
        tick();
        req[1] = 1'b1;
        for (int k = 0; k < 3; k++) begin
            wait_gnt(g, lat);
            e = rr_expect(vec, m_last);
            checks++;
            if (g !== onehot(e) || (k != 1 && e != 3) || (k == 1 && e != 1)) begin
                errors++; $display("FAIL hold_order[%0d]: got %b want %b", k, g, onehot(e));
            end
            if (k > 0) begin
                checks++;
                if (lat != 4) begin
                    errors++; $display("FAIL hold_spacing[%0d]: got %0d want 4", k, lat);
                end
            end
            m_last = e;
            if (e == 1) req[1] = 1'b0;
            vec = req;
        end
        req = '0;
        tick();
        tick();
    endtask

    task automatic test_reset_mid;
        int pulses;
        set_core(0, 1'b0, 12'h007, '0);
        req[0] = 1'b1;
        tick();
        tick();
        checks++;
        if (busy !== 1'b1 || mem_en !== 1'b0) begin
            errors++; $display("FAIL mid_setup: got busy=%b en=%b want 1 0", busy, mem_en);
        end
        reset = 1'b0;
        tick();
        req = '0;
        checks++;
        if ({busy, gnt, mem_en, mem_we, mem_addr, mem_wdata, rdata} !== '0) begin
            errors++; $display("FAIL mid_reset_outputs: got busy=%b gnt=%b en=%b we=%b addr=%h rdata=%h want 0",
                               busy, gnt, mem_en, mem_we, mem_addr, rdata);
        end
        reset  = 1'b1;
        m_last = N - 1;
        pulses = 0;
        for (int k = 0; k < 6; k++) begin
            tick();
            if (gnt !== '0) pulses++;
        end
        checks++;
        if (pulses != 0) begin
            errors++; $display("FAIL mid_no_gnt: got %0d pulses want 0", pulses);
        end
    endtask

    task automatic test_random;
        logic [N-1:0] g;
        logic [W-1:0] a;
        int           lat;
        int           e;
        for (int c = 0; c < N; c++) begin
            set_core(c, 1'($urandom_range(0, 1)), W'($urandom_range(0, 15)), W'($urandom));
            req[c] = 1'($urandom_range(0, 1));
        end
        if (req == '0) req[$urandom_range(0, N - 1)] = 1'b1;
        for (int k = 0; k < 60; k++) begin
            wait_gnt(g, lat);
            e = rr_expect(req, m_last);
            checks++;
            if (g !== onehot(e) || lat != ((k == 0) ? 3 : 4)) begin
                errors++; $display("FAIL rand_gnt[%0d]: got %b lat %0d want %b lat %0d", k, g, lat, onehot(e), (k == 0) ? 3 : 4);
            end
            if (e >= 0) begin
                a = addr[e*W +: W];
                if (we[e]) begin
                    exp_mem[a]   = wdata[e*W +: W];
                    exp_valid[a] = 1'b1;
                end else begin
                    checks++;
                    if (rdata !== model_read(a)) begin
                        errors++; $display("FAIL rand_rdata[%0d]: got %h want %h", k, rdata, model_read(a));
                    end
                end
                m_last = e;
            end
            for (int c = 0; c < N; c++) begin
                if (c == e || !req[c]) begin
                    req[c] = 1'($urandom_range(0, 1));
                    set_core(c, 1'($urandom_range(0, 1)), W'($urandom_range(0, 15)), W'($urandom));
                end
            end
            if (req == '0) req[$urandom_range(0, N - 1)] = 1'b1;
        end
        req = '0;
        tick();
        tick();
    endtask

`ifdef DMEM_ARB_STATS_EN
    task automatic test_stats;
        logic [N-1:0] g;
        int           lat;
        do_reset();
        checks++;
        if (grant_cnt !== '0) begin
            errors++; $display("FAIL stats_reset: got %h want 0", grant_cnt);
        end
        set_core(0, 1'b0, 12'h001, '0);
        req[0] = 1'b1;
        for (int k = 0; k < 300; k++) begin
            wait_gnt(g, lat);
            checks++;
            if (g !== 4'b0001) begin
                errors++; $display("FAIL stats_gnt[%0d]: got %b want 0001", k, g);
            end
            if (k == 10) begin
                checks++;
                if (grant_cnt[7:0] !== 8'd10) begin
                    errors++; $display("FAIL stats_count10: got %0d want 10", grant_cnt[7:0]);
                end
            end
        end
        req = '0;
        tick();
        tick();
        checks++;
        if (grant_cnt[7:0] !== 8'd255) begin
            errors++; $display("FAIL stats_saturate: got %0d want 255", grant_cnt[7:0]);
        end
        checks++;
        if (grant_cnt[N*8-1:8] !== '0) begin
            errors++; $display("FAIL stats_others: got %h want 0", grant_cnt[N*8-1:8]);
        end
    endtask
`endif

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_read();
        test_write_read();
        test_all_req();
        test_hold_req();
        test_reset_mid();
        test_random();
`ifdef DMEM_ARB_STATS_EN
        test_stats();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
